// File: rtl/wishbone_sram_slave.sv
// wishbone_sram_slave: classic Wishbone responder backed by a byte-lane-writable scratchpad RAM
// with programmable wait states and an error response for out-of-range or misaligned addresses.
module wishbone_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 3,
  parameter int ORIGIN      = 0,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [TAG_WIDTH-1:0]    wb_tag,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [DATA_WIDTH-1:0]   wb_mosi,
  output logic [DATA_WIDTH-1:0]   wb_miso,
  output logic                    wb_ack,
  output logic                    wb_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] P_LO   = ADDR_WIDTH'(ORIGIN);
  localparam logic [ADDR_WIDTH-1:0] P_SPAN = ADDR_WIDTH'(4 * DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_req, w_idle, w_hit_in, w_hit, w_we, w_enter, w_unused;
  logic [IW-1:0]         w_idx, r_idx;
  logic [NB-1:0]         w_sel, r_sel;
  logic [DATA_WIDTH-1:0] w_dat, r_dat;
  logic                  r_hit, r_we;
  logic [3:0]            r_cnt;
  // An address below ORIGIN wraps to a huge offset, so one compare covers both bounds
  assign w_off    = wb_adr - P_LO;
  assign w_req    = wb_cyc && wb_stb;
  assign w_idle   = r_state == S_IDLE;
  assign w_hit_in = (w_off < P_SPAN) && (wb_adr[1:0] == 2'b00);
  // With no wait states RESP is entered on the request edge itself, before the latches hold it
  assign w_hit    = w_idle ? w_hit_in : r_hit;
  assign w_we     = w_idle ? wb_we : r_we;
  assign w_idx    = w_idle ? w_off[IW+1:2] : r_idx;
  assign w_sel    = w_idle ? wb_sel : r_sel;
  assign w_dat    = w_idle ? wb_mosi : r_dat;
  assign w_enter  = (w_next == S_RESP) && sys_rst;
  assign w_unused = ^{wb_tag, w_off};
  always_comb begin
    w_next = r_state == S_IDLE ? (w_req ? (WAIT_STATES > 0 ? S_WAIT : S_RESP) : S_IDLE)
           : r_state == S_WAIT ? (!wb_cyc ? S_IDLE : (r_cnt == 4'd0 ? S_RESP : S_WAIT))
           : S_IDLE;
  end
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
      wb_ack  <= 1'b0;
      wb_err  <= 1'b0;
      wb_miso <= '0;
    end else begin
      r_state <= w_next;
      wb_ack  <= (r_state == S_RESP) && r_hit;
      wb_err  <= (r_state == S_RESP) && !r_hit;
      if (w_idle && w_req) begin
        r_hit <= w_hit_in;
        r_we  <= wb_we;
        r_idx <= w_off[IW+1:2];
        r_sel <= wb_sel;
        r_dat <= wb_mosi;
        r_cnt <= 4'(WAIT_STATES - 1);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter && w_hit && !w_we) wb_miso <= r_mem[w_idx];
    end
  end
  always_ff @(posedge sys_clk) begin
    if (w_enter && w_hit && w_we)
      for (int i = 0; i < NB; i++)
        if (w_sel[i]) r_mem[w_idx][8*i +: 8] <= w_dat[8*i +: 8];
  end
endmodule

// File: tb/tb_wishbone_sram_slave.sv
// tb_wishbone_sram_slave: directed bench with a response scoreboard for a zero-wait and a
// three-wait-state responder sharing the same bus signals (each has its own cyc/stb).
module tb_wishbone_sram_slave;
  typedef struct {bit err; logic [31:0] miso; int lat;} exp_t;
  logic        clk = 0, rst_n = 0;
  logic        cyc0 = 0, stb0 = 0, cyc3 = 0, stb3 = 0, we = 0;
  logic [2:0]  tag = '0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, mosi = '0;
  logic [31:0] miso0, miso3;
  logic        ack0, err0, ack3, err3;
  int          vectors = 0, miscompares = 0;
  exp_t        exp_q[$];

  wishbone_sram_slave #(.ORIGIN(32'h400), .DEPTH(256), .WAIT_STATES(0)) u0 (
    .sys_clk(clk), .sys_rst(rst_n), .wb_cyc(cyc0), .wb_stb(stb0), .wb_we(we), .wb_tag(tag),
    .wb_sel(sel), .wb_adr(adr), .wb_mosi(mosi), .wb_miso(miso0), .wb_ack(ack0), .wb_err(err0));
  wishbone_sram_slave #(.ORIGIN(32'h400), .DEPTH(256), .WAIT_STATES(3)) u3 (
    .sys_clk(clk), .sys_rst(rst_n), .wb_cyc(cyc3), .wb_stb(stb3), .wb_we(we), .wb_tag(tag),
    .wb_sel(sel), .wb_adr(adr), .wb_mosi(mosi), .wb_miso(miso3), .wb_ack(ack3), .wb_err(err3));

  always #5 clk = ~clk;

  task automatic chk(input string tag_s, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag_s, obs, expv);
    end
  endtask

  task automatic xfer(input bit d, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] dat, input bit e_err, input logic [31:0] e_miso);
    exp_t e;
    int   n = 0;
    exp_q.push_back('{e_err, e_miso, d ? 4 : 1});
    if (d) begin cyc3 = 1; stb3 = 1; end else begin cyc0 = 1; stb0 = 1; end
    we = w; adr = a; sel = s; mosi = dat;
    @(posedge clk); #1;
    while (n < 20 && !(d ? (ack3 | err3) : (ack0 | err0))) begin
      @(posedge clk); #1;
      n++;
    end
    cyc0 = 0; stb0 = 0; cyc3 = 0; stb3 = 0;
    e = exp_q.pop_front();
    chk("latency", n, e.lat);
    chk("ack", d ? ack3 : ack0, !e.err);
    chk("err", d ? err3 : err0, e.err);
    chk("miso", d ? miso3 : miso0, e.miso);
    @(posedge clk); #1;
    chk("pulse_end", d ? (ack3 | err3) : (ack0 | err0), 0);
  endtask

  initial begin
    exp_t e;
    int   n, k, prev;
    logic seen;
    logic [31:0] b2b_adr [3];
    b2b_adr[0] = 32'h400; b2b_adr[1] = 32'h404; b2b_adr[2] = 32'h408;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_ack0", ack0, 0); chk("rst_err0", err0, 0); chk("rst_miso0", miso0, 0);
    chk("rst_ack3", ack3, 0); chk("rst_miso3", miso3, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ack0", ack0 | err0, 0); chk("idle_miso0", miso0, 0);
    // full-word write and read-back, then byte-lane and empty-lane writes
    xfer(0, 1, 32'h404, 4'hF, 32'hDEADBEEF, 0, 32'h0);
    xfer(0, 0, 32'h404, 4'hF, 32'h0, 0, 32'hDEADBEEF);
    xfer(0, 1, 32'h404, 4'b0010, 32'h00005500, 0, 32'hDEADBEEF);
    xfer(0, 0, 32'h404, 4'hF, 32'h0, 0, 32'hDEAD55EF);
    xfer(0, 1, 32'h404, 4'h0, 32'hFFFFFFFF, 0, 32'hDEAD55EF);
    xfer(0, 0, 32'h404, 4'hF, 32'h0, 0, 32'hDEAD55EF);
    // misses: below region, one past the top, misaligned
    xfer(0, 0, 32'h3FC, 4'hF, 32'h0, 1, 32'hDEAD55EF);
    xfer(0, 1, 32'h800, 4'hF, 32'h01010101, 1, 32'hDEAD55EF);
    xfer(0, 1, 32'h406, 4'hF, 32'h02020202, 1, 32'hDEAD55EF);
    xfer(0, 0, 32'h406, 4'hF, 32'h0, 1, 32'hDEAD55EF);
    xfer(0, 0, 32'h404, 4'hF, 32'h0, 0, 32'hDEAD55EF);
    xfer(0, 1, 32'h7FC, 4'hF, 32'h12345678, 0, 32'hDEAD55EF);
    xfer(0, 0, 32'h7FC, 4'hF, 32'h0, 0, 32'h12345678);
    xfer(0, 1, 32'h400, 4'hF, 32'hA5A50001, 0, 32'h12345678);
    xfer(0, 1, 32'h408, 4'hF, 32'h5A5A0002, 0, 32'h12345678);
    // back-to-back reads with cyc/stb held, address advanced as each ack appears
    exp_q.push_back('{0, 32'hA5A50001, 2});
    exp_q.push_back('{0, 32'hDEAD55EF, 2});
    exp_q.push_back('{0, 32'h5A5A0002, 2});
    cyc0 = 1; stb0 = 1; we = 0; sel = 4'hF; adr = b2b_adr[0];
    n = 0; k = 0; prev = 0;
    while (k < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack0 | err0) begin
        e = exp_q.pop_front();
        chk("b2b_ack", ack0, 1);
        chk("b2b_miso", miso0, e.miso);
        chk("b2b_gap", n - prev, e.lat);
        prev = n;
        k++;
        if (k < 3) adr = b2b_adr[k];
        else begin cyc0 = 0; stb0 = 0; end
      end
    end
    cyc0 = 0; stb0 = 0;
    chk("b2b_count", k, 3);
    @(posedge clk); #1;
    chk("b2b_end", ack0 | err0, 0);
    // three wait states: latency, then an aborted write
    xfer(1, 1, 32'h404, 4'hF, 32'hCAFEF00D, 0, 32'h0);
    xfer(1, 0, 32'h404, 4'hF, 32'h0, 0, 32'hCAFEF00D);
    cyc3 = 1; stb3 = 1; we = 1; adr = 32'h404; sel = 4'hF; mosi = 32'h11111111;
    repeat (3) @(posedge clk);
    #1;
    cyc3 = 0; stb3 = 0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen |= ack3 | err3; end
    chk("abort_resp", seen, 0);
    xfer(1, 0, 32'h404, 4'hF, 32'h0, 0, 32'hCAFEF00D);
    // reset while waiting drops the transfer
    cyc3 = 1; stb3 = 1; we = 0; adr = 32'h404;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0; cyc3 = 0; stb3 = 0;
    #1;
    chk("rstw_ack", ack3 | err3, 0);
    chk("rstw_miso", miso3, 0);
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen |= ack3 | err3; end
    chk("rstw_resp", seen, 0);
    xfer(1, 0, 32'h404, 4'hF, 32'h0, 0, 32'hCAFEF00D);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
